song_block_streamer: RTL and testbench

Parametrised successor to the single-index block reader. Given a song number, the block walks that song's blocks in order. For each block it reads one word from a synchronous-read block memory, unpacks the block size and up to MAX_NOTES notes, and tracks the previous block's size. Each block is presented downstream on a valid/ready handshake. It sits between the song block ROM and the feature/emotion extraction pipeline.

---
 rtl/song_block_pkg.sv | 30 +++
 rtl/song_block_streamer_unpack.sv | 32 +++
 rtl/song_block_streamer.sv | 171 +++++++++++++++++
 tb/tb_song_block_streamer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_block_pkg.sv
// Shared defaults, state encoding and word-layout helper
// for the song block streamer.
package song_block_pkg;

   localparam int NOTE_W_DEF          = 16;
   localparam int MAX_NOTES_DEF       = 4;
   localparam int SIZE_W_DEF          = 3;
   localparam int BLOCKS_PER_SONG_DEF = 16;
   localparam int NUM_SONGS_DEF       = 32;
   localparam int IDX_W_DEF           =
      $clog2(NUM_SONGS_DEF * BLOCKS_PER_SONG_DEF);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // LSB of note slot k inside a memory word.
   function automatic int note_lsb(
      input int size_w,
      input int note_w,
      input int k
   );
      return size_w + k * note_w;
   endfunction

endpackage

// File: rtl/song_block_streamer_unpack.sv
// Combinational unpack of one block word: size clamp,
// clamp flag, end marker detect and unused-slot masking.
module block_word_unpack
   import song_block_pkg::*;
#(
   parameter int NOTE_W    = NOTE_W_DEF,
   parameter int MAX_NOTES = MAX_NOTES_DEF,
   parameter int SIZE_W    = SIZE_W_DEF
) (
   input  logic [SIZE_W+MAX_NOTES*NOTE_W-1:0] word_i,
   output logic [SIZE_W-1:0]                  size_o,
   output logic [MAX_NOTES*NOTE_W-1:0]        notes_o,
   output logic                               clamp_o,
   output logic                               zero_o
);

   localparam logic [SIZE_W-1:0] MAX_L = SIZE_W'(MAX_NOTES);

   logic [SIZE_W-1:0] raw;

   assign raw     = word_i[SIZE_W-1:0];
   assign zero_o  = (raw == '0);
   assign clamp_o = (raw > MAX_L);
   assign size_o  = clamp_o ? MAX_L : raw;

   for (genvar k = 0; k < MAX_NOTES; k++) begin : g_note
      localparam int LSB = note_lsb(SIZE_W, NOTE_W, k);
      assign notes_o[k*NOTE_W +: NOTE_W] =
         (int'(size_o) > k) ? word_i[LSB +: NOTE_W] : '0;
   end

endmodule

// File: rtl/song_block_streamer.sv
// Walks one song's blocks through a sync-read ROM and
// presents each unpacked block on a valid/ready port.
module song_block_streamer
   import song_block_pkg::*;
#(
   parameter int NOTE_W          = NOTE_W_DEF,
   parameter int MAX_NOTES       = MAX_NOTES_DEF,
   parameter int SIZE_W          = SIZE_W_DEF,
   parameter int BLOCKS_PER_SONG = BLOCKS_PER_SONG_DEF,
   parameter int NUM_SONGS       = NUM_SONGS_DEF,
   parameter int IDX_W           =
      $clog2(NUM_SONGS * BLOCKS_PER_SONG),
   // one spare bit so out-of-range selections can be seen
   localparam int SEL_W   = $clog2(NUM_SONGS + 1),
   localparam int NOTES_W = MAX_NOTES * NOTE_W,
   localparam int WORD_W  = SIZE_W + NOTES_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [SEL_W-1:0]   song_sel,
   input  logic               abort,
   output logic               mem_rd_en,
   output logic [IDX_W-1:0]   mem_addr,
   input  logic [WORD_W-1:0]  mem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NOTES_W-1:0] out_notes,
   output logic [SIZE_W-1:0]  out_block_size,
   output logic [SIZE_W-1:0]  out_prev_block_size,
   output logic [IDX_W-1:0]   out_block_idx,
   output logic               out_last,
   output logic               done,
   output logic               err
);

   localparam int BLK_W = $clog2(BLOCKS_PER_SONG);
   localparam logic [BLK_W-1:0] BLK_LAST =
      BLK_W'(BLOCKS_PER_SONG - 1);
   localparam logic [SEL_W-1:0] SONGS_L = SEL_W'(NUM_SONGS);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   song_q, song_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic [SIZE_W-1:0]  prev_q, prev_d;
   logic [SIZE_W-1:0]  size_q, size_d;
   logic [NOTES_W-1:0] notes_q, notes_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               last_q, last_d;
   logic               err_q, err_d;

   logic [SIZE_W-1:0]  u_size;
   logic [NOTES_W-1:0] u_notes;
   logic               u_clamp;
   logic               u_zero;

   logic               sel_ok;
   logic               accept;
   logic               reject;
   logic               kill;
   logic               hs;
   logic [IDX_W-1:0]   addr;

   block_word_unpack #(
      .NOTE_W    (NOTE_W),
      .MAX_NOTES (MAX_NOTES),
      .SIZE_W    (SIZE_W)
   ) u_unpack (
      .word_i  (mem_rdata),
      .size_o  (u_size),
      .notes_o (u_notes),
      .clamp_o (u_clamp),
      .zero_o  (u_zero)
   );

   assign sel_ok = (song_sel < SONGS_L);
   assign accept = (state_q == S_IDLE) && start && sel_ok;
   assign reject = (state_q == S_IDLE) && start && !sel_ok;
   assign kill   = abort && (state_q != S_IDLE);
   assign hs     = (state_q == S_HOLD) && out_ready;
   assign addr   = (IDX_W'(song_q) << BLK_W) | IDX_W'(blk_q);

   // Sequencing: fetch, wait a cycle for data, hold until taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT:  state_d = u_zero ? S_DONE : S_HOLD;
         S_HOLD: begin
            if (out_ready) state_d = last_q ? S_DONE : S_FETCH;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (kill) state_d = S_IDLE;
   end

   // Song/block counters, captured block fields and sticky error.
   always_comb begin
      song_d  = song_q;
      blk_d   = blk_q;
      prev_d  = prev_q;
      size_d  = size_q;
      notes_d = notes_q;
      idx_d   = idx_q;
      last_d  = last_q;
      err_d   = err_q;
      if (accept) begin
         song_d = song_sel;
         blk_d  = '0;
         prev_d = '0;
         err_d  = 1'b0;
      end
      if (reject) err_d = 1'b1;
      if (!kill) begin
         if (state_q == S_WAIT) begin
            notes_d = u_notes;
            size_d  = u_size;
            idx_d   = addr;
            last_d  = (blk_q == BLK_LAST);
            if (u_clamp) err_d = 1'b1;
         end
         if (hs) begin
            prev_d = size_q;
            if (!last_q) blk_d = blk_q + BLK_W'(1);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         song_q  <= '0;
         blk_q   <= '0;
         prev_q  <= '0;
         size_q  <= '0;
         notes_q <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         song_q  <= song_d;
         blk_q   <= blk_d;
         prev_q  <= prev_d;
         size_q  <= size_d;
         notes_q <= notes_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   assign mem_rd_en           = (state_q == S_FETCH);
   assign mem_addr            = mem_rd_en ? addr : '0;
   assign out_valid           = (state_q == S_HOLD);
   assign out_notes           = notes_q;
   assign out_block_size      = size_q;
   assign out_prev_block_size = prev_q;
   assign out_block_idx       = idx_q;
   assign out_last            = last_q & out_valid;
   assign done                = (state_q == S_DONE);
   assign err                 = err_q;

endmodule

// File: tb/tb_song_block_streamer.sv
// Bench for song_block_streamer: ROM model, song-level
// reference queue, per-cycle compare and directed checks.
module tb_song_block_streamer;

   localparam int NW  = 16;
   localparam int MN  = 4;
   localparam int SW  = 3;
   localparam int BPS = 16;
   localparam int IW  = 9;
   localparam int WW  = SW + MN * NW;
   localparam int NTW = MN * NW;

   typedef struct packed {
      logic [NTW-1:0] notes;
      logic [SW-1:0]  size;
      logic [SW-1:0]  prev;
      logic [IW-1:0]  idx;
      logic           last;
      logic           clamp;
   } exp_t;

   logic           clk;
   logic           rst;
   logic           start;
   logic [5:0]     song_sel;
   logic           abort;
   logic           mem_rd_en;
   logic [IW-1:0]  mem_addr;
   logic [WW-1:0]  mem_rdata;
   logic           out_valid;
   logic           out_ready;
   logic [NTW-1:0] out_notes;
   logic [SW-1:0]  out_block_size;
   logic [SW-1:0]  out_prev_block_size;
   logic [IW-1:0]  out_block_idx;
   logic           out_last;
   logic           done;
   logic           err;

   logic [WW-1:0]  mem [0:511];

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   bit   active = 0;
   bit   exp_err = 0;
   int   exp_sel = 0;
   int   nxt_blk = 0;
   int   n_emit = 0;
   bit   prev_done = 0;

   song_block_streamer dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .song_sel            (song_sel),
      .abort               (abort),
      .mem_rd_en           (mem_rd_en),
      .mem_addr            (mem_addr),
      .mem_rdata           (mem_rdata),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_notes           (out_notes),
      .out_block_size      (out_block_size),
      .out_prev_block_size (out_prev_block_size),
      .out_block_idx       (out_block_idx),
      .out_last            (out_last),
      .done                (done),
      .err                 (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // synchronous-read ROM
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic req(input string nm, input bit c);
      tests++;
      if (!c) begin
         fails++;
         $display("FAIL %s: got 0 want 1", nm);
      end
   endtask

   // expected block list for song s, straight from the ROM image
   task automatic load_model(input int s);
      logic [WW-1:0] w;
      int raw;
      int sz;
      int pv;
      exp_t e;
      q.delete();
      pv = 0;
      for (int b = 0; b < BPS; b++) begin
         w = mem[s*BPS+b];
         raw = int'(w[SW-1:0]);
         if (raw == 0) break;
         sz = (raw > MN) ? MN : raw;
         e.notes = '0;
         for (int k = 0; k < sz; k++)
            e.notes[k*NW +: NW] = w[SW+k*NW +: NW];
         e.size  = SW'(sz);
         e.prev  = SW'(pv);
         e.idx   = IW'(s*BPS+b);
         e.last  = (b == BPS-1);
         e.clamp = (raw > MN);
         q.push_back(e);
         pv = sz;
      end
      active  = 1;
      exp_sel = s;
      nxt_blk = 0;
      n_emit  = 0;
   endtask

   task automatic start_song(input int s);
      @(posedge clk);
      #1;
      start = 1'b1;
      song_sel = 6'(s);
      load_model(s);
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_err = 0;
   endtask

   task automatic wait_valid_idx(input int idx, input int budget);
      bit hit;
      hit = 0;
      for (int c = 0; c < budget && !hit; c++) begin
         @(negedge clk);
         if (out_valid && out_block_idx == IW'(idx)) hit = 1;
      end
      req($sformatf("wait_valid_%0d", idx), hit);
   endtask

   task automatic wait_done(input int budget);
      bit hit;
      hit = 0;
      for (int c = 0; c < budget && !hit; c++) begin
         @(negedge clk);
         if (done) hit = 1;
      end
      req("wait_done", hit);
   endtask

   // per-cycle comparison against the reference queue
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            req("m_valid_expected", q.size() != 0);
            if (q.size() != 0) begin
               if (q[0].clamp) exp_err = 1;
               chk("m_notes", out_notes, q[0].notes);
               chk("m_size", out_block_size, q[0].size);
               chk("m_prev", out_prev_block_size, q[0].prev);
               chk("m_idx", out_block_idx, q[0].idx);
               chk("m_last", out_last, q[0].last);
            end
         end
         chk("m_err", err, exp_err);
         if (mem_rd_en) begin
            req("m_rd_active", active);
            chk("m_rd_addr", mem_addr, 64'(exp_sel*BPS+nxt_blk));
            req("m_rd_no_valid", !out_valid);
         end
         if (done) begin
            req("m_done_active", active);
            req("m_done_empty", q.size() == 0);
            req("m_done_single", !prev_done);
            active = 0;
         end
         if (abort) begin
            q.delete();
            active = 0;
         end else if (out_valid && out_ready && q.size() != 0) begin
            void'(q.pop_front());
            nxt_blk++;
            n_emit++;
         end
      end
      prev_done = done;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WW-1:0] w;
      for (int i = 0; i < 512; i++) begin
         w = '0;
         for (int k = 0; k < MN; k++)
            w[SW+k*NW +: NW] = NW'(i*37 + k*1111 + 5);
         w[SW-1:0] = (i < 16) ? 3'd4 : SW'(((i*5+3) % 4) + 1);
         mem[i] = w;
      end
      mem[17][SW-1:0] = 3'd3;
      mem[18] = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA, 3'd2};
      mem[36][SW-1:0] = 3'd7;
      mem[51][SW-1:0] = 3'd0;

      rst = 1'b1;
      start = 1'b0;
      song_sel = '0;
      abort = 1'b0;
      out_ready = 1'b1;
      mem_rdata = '0;
      #1;
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_notes", out_notes, 0);
      chk("rst_idx", out_block_idx, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // song 0: timing and full walk
      start_song(0);
      @(negedge clk);
      chk("s0_fetch_rd", mem_rd_en, 1);
      chk("s0_fetch_vld", out_valid, 0);
      @(negedge clk);
      chk("s0_wait_vld", out_valid, 0);
      @(negedge clk);
      chk("s0_first_vld", out_valid, 1);
      chk("s0_first_idx", out_block_idx, 0);
      chk("s0_first_prev", out_prev_block_size, 0);
      chk("s0_first_size", out_block_size, 4);
      chk("s0_first_last", out_last, 0);
      wait_valid_idx(1, 6);
      chk("s0_b1_prev", out_prev_block_size, 4);
      wait_valid_idx(15, 60);
      chk("s0_b15_last", out_last, 1);
      @(negedge clk);
      chk("s0_done", done, 1);
      @(negedge clk);
      chk("s0_done_end", done, 0);
      chk("s0_idle_vld", out_valid, 0);
      chk("s0_count", n_emit, 16);

      // song 1: partial block masking
      start_song(1);
      wait_valid_idx(18, 40);
      chk("s1_notes", out_notes, 64'h0000_0000_BBBB_AAAA);
      chk("s1_size", out_block_size, 2);
      chk("s1_prev", out_prev_block_size, 3);
      wait_done(100);

      // song 2: size clamp and sticky error
      start_song(2);
      wait_valid_idx(36, 40);
      chk("s2_size", out_block_size, 4);
      chk("s2_err", err, 1);
      wait_done(100);
      @(negedge clk);
      chk("s2_err_sticky", err, 1);

      // song 3: end marker at block 51
      start_song(3);
      chk("s3_err_clr", err, 0);
      wait_valid_idx(50, 40);
      @(negedge clk);
      chk("s3_fetch51", mem_addr, 51);
      @(negedge clk);
      chk("s3_wait_vld", out_valid, 0);
      @(negedge clk);
      chk("s3_done", done, 1);
      chk("s3_count", n_emit, 3);

      // song 4: backpressure on block 1
      out_ready = 1'b0;
      start_song(4);
      wait_valid_idx(64, 20);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      wait_valid_idx(65, 20);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_idx", out_block_idx, 65);
         chk("bp_rd_en", mem_rd_en, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_done(200);
      chk("bp_count", n_emit, 16);

      // song 5: abort while holding
      out_ready = 1'b0;
      start_song(5);
      wait_valid_idx(80, 20);
      @(posedge clk);
      #1;
      abort = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ab_valid", out_valid, 0);
      chk("ab_rd_en", mem_rd_en, 0);
      abort = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("ab_no_done", done, 0);
         chk("ab_no_vld", out_valid, 0);
      end

      // out-of-range song select
      @(posedge clk);
      #1;
      start = 1'b1;
      song_sel = 6'd32;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_err = 1;
      chk("bad_err", err, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bad_vld", out_valid, 0);
         chk("bad_rd_en", mem_rd_en, 0);
      end

      // reset in the middle of a fetch
      start_song(6);
      chk("rf_rd_en", mem_rd_en, 1);
      chk("rf_addr", mem_addr, 96);
      rst = 1'b1;
      q.delete();
      active = 0;
      exp_err = 0;
      #1;
      chk("rf_rd_en0", mem_rd_en, 0);
      chk("rf_addr0", mem_addr, 0);
      chk("rf_valid0", out_valid, 0);
      chk("rf_notes0", out_notes, 0);
      chk("rf_size0", out_block_size, 0);
      chk("rf_prev0", out_prev_block_size, 0);
      chk("rf_idx0", out_block_idx, 0);
      chk("rf_last0", out_last, 0);
      chk("rf_done0", done, 0);
      chk("rf_err0", err, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // recovery after reset
      start_song(7);
      wait_done(100);
      chk("s7_count", n_emit, 16);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
